// File: rtl/iob_bus_merge2_pkg.sv
// Shared definitions for the 2-to-1 IOb bus merger.
// The FSM state encoding, the response bit positions and the helpers that derive
// the packed req/resp widths from ADDR_W/DATA_W all live here.
// req  = {avalid, addr[ADDR_W], wdata[DATA_W], wstrb[DATA_W/8]}
// resp = {rdata[DATA_W], rvalid, ready}
package iob_bus_merge2_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      RD_WAIT = 1'b1
   } state_t;

   // Response field positions; rdata starts right above rvalid.
   localparam int RESP_READY_POS  = 0;
   localparam int RESP_RVALID_POS = 1;
   localparam int RESP_RDATA_LSB  = 2;

   function automatic int req_width(input int addr_w, input int data_w);
      return 1 + addr_w + data_w + data_w / 8;
   endfunction

   function automatic int resp_width(input int data_w);
      return data_w + 2;
   endfunction

endpackage

// File: rtl/iob_bus_merge2_arb.sv
// Grant selection for the bus merger.
// Build option: define IOB_BUS_MERGE2_RR_EN for round-robin arbitration;
// without it master 1 (data bus) always beats master 0 (instruction bus).
// gnt is 0 for master 0, 1 for master 1; with no request it reads 0.
module iob_bus_merge2_arb (
   input  logic req0,
   input  logic req1,
   input  logic rr_last,
   output logic gnt
);

`ifdef IOB_BUS_MERGE2_RR_EN
   // On contention the master that did not win last time gets the bus;
   // a lone requester is always granted.
   assign gnt = (req0 & req1) ? ~rr_last : req1;
`else
   // Data bus has fixed priority; req0 and rr_last do not affect the outcome.
   assign gnt = req1;

   logic unused_arb_inputs;
   assign unused_arb_inputs = req0 ^ rr_last;
`endif

endmodule

// File: rtl/iob_bus_merge2.sv
// 2-to-1 IOb native-bus merger: instruction bus (m0) and data bus (m1) share one
// slave port. New requests are arbitrated only in IDLE; an accepted read locks the
// bus until the slave returns rvalid, which is routed only to the issuing master.
// Build option: IOB_BUS_MERGE2_RR_EN selects round-robin arbitration (see arb).
// All outputs are combinational from the registered state and are forced to zero
// while rst_i is high.
module iob_bus_merge2
   import iob_bus_merge2_pkg::*;
#(
   parameter  int ADDR_W  = 32,
   parameter  int DATA_W  = 32,
   localparam int WSTRB_W = DATA_W / 8,
   localparam int REQ_W   = req_width(ADDR_W, DATA_W),
   localparam int RESP_W  = resp_width(DATA_W)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cke_i,
   input  logic [REQ_W-1:0]  m0_req,
   output logic [RESP_W-1:0] m0_resp,
   input  logic [REQ_W-1:0]  m1_req,
   output logic [RESP_W-1:0] m1_resp,
   output logic [REQ_W-1:0]  s_req,
   input  logic [RESP_W-1:0] s_resp
);

   localparam int AVALID_POS = REQ_W - 1;

   state_t state_reg, state_next;
   logic   owner_reg, owner_next;
   logic   rr_last_reg, rr_last_next;

   logic              m0_avalid, m1_avalid;
   logic              gnt;
   logic [REQ_W-1:0]  gnt_req;
   logic              gnt_avalid;
   logic              gnt_is_read;
   logic              s_ready, s_rvalid;
   logic [DATA_W-1:0] s_rdata;
   logic              active, in_idle, in_rd_wait;
   logic              accept, rd_done;

   assign m0_avalid = m0_req[AVALID_POS];
   assign m1_avalid = m1_req[AVALID_POS];

   assign s_ready  = s_resp[RESP_READY_POS];
   assign s_rvalid = s_resp[RESP_RVALID_POS];
   assign s_rdata  = s_resp[RESP_W-1:RESP_RDATA_LSB];

   iob_bus_merge2_arb u_arb (
      .req0    (m0_avalid),
      .req1    (m1_avalid),
      .rr_last (rr_last_reg),
      .gnt     (gnt)
   );

   assign gnt_req     = gnt ? m1_req : m0_req;
   assign gnt_avalid  = gnt_req[AVALID_POS];
   assign gnt_is_read = (gnt_req[WSTRB_W-1:0] == '0);

   // Reset masks every output so nothing leaks while state is being cleared.
   assign active     = ~rst_i;
   assign in_idle    = active & (state_reg == IDLE);
   assign in_rd_wait = active & (state_reg == RD_WAIT);

   assign accept  = in_idle & gnt_avalid & s_ready;
   assign rd_done = in_rd_wait & s_rvalid;

   // Slave sees the granted request only in IDLE; the bus is quiet while a read is outstanding.
   assign s_req = (in_idle & gnt_avalid) ? gnt_req : '0;

   // Route ready to the granted master in IDLE and read data to the read owner in RD_WAIT.
   always_comb begin
      m0_resp = '0;
      m1_resp = '0;
      if (in_idle & gnt_avalid) begin
         if (gnt) begin
            m1_resp[RESP_READY_POS] = s_ready;
         end else begin
            m0_resp[RESP_READY_POS] = s_ready;
         end
      end
      if (rd_done) begin
         if (owner_reg) begin
            m1_resp[RESP_W-1:RESP_RVALID_POS] = {s_rdata, 1'b1};
         end else begin
            m0_resp[RESP_W-1:RESP_RVALID_POS] = {s_rdata, 1'b1};
         end
      end
   end

   // Next state: writes complete at accept, reads park in RD_WAIT until rvalid.
   always_comb begin
      state_next   = state_reg;
      owner_next   = owner_reg;
      rr_last_next = rr_last_reg;
      if (state_reg == IDLE) begin
         if (accept) begin
            rr_last_next = gnt;
            if (gnt_is_read) begin
               owner_next = gnt;
               state_next = RD_WAIT;
            end
         end
      end else begin
         if (s_rvalid) begin
            state_next = IDLE;
         end
      end
   end

   // Control registers; reset wins over cke_i, cke_i low freezes them otherwise.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg   <= IDLE;
         owner_reg   <= 1'b0;
         rr_last_reg <= 1'b1;
      end else if (cke_i) begin
         state_reg   <= state_next;
         owner_reg   <= owner_next;
         rr_last_reg <= rr_last_next;
      end
   end

endmodule

// File: tb/tb_iob_bus_merge2.sv
// Directed bench for iob_bus_merge2 with a scoreboard: the stimulus pushes
// expected slave accepts and expected master read returns into queues, and a
// monitor on the falling edge pops and compares whatever the DUT presents.
module tb_iob_bus_merge2;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8;
   localparam int RESP_W = DATA_W + 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cke = 1'b1;
   logic [REQ_W-1:0]  m0_req, m1_req, s_req;
   logic [RESP_W-1:0] m0_resp, m1_resp, s_resp;
   logic              s_ready, s_rvalid;
   logic [31:0]       s_rdata;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int          m;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } acc_t;

   typedef struct {
      int          m;
      logic [31:0] data;
   } rd_t;

   acc_t acc_q[$];
   rd_t  rd_q[$];

   assign s_resp = {s_rdata, s_rvalid, s_ready};

   always #5 clk = ~clk;

   iob_bus_merge2 #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .cke_i   (cke),
      .m0_req  (m0_req),
      .m0_resp (m0_resp),
      .m1_req  (m1_req),
      .m1_resp (m1_resp),
      .s_req   (s_req),
      .s_resp  (s_resp)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int m, input logic v, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
      if (m == 0) m0_req = {v, a, d, s};
      else        m1_req = {v, a, d, s};
   endtask

   task automatic exp_acc(input int m, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s);
      acc_t e;
      e.m = m; e.addr = a; e.wdata = d; e.wstrb = s;
      acc_q.push_back(e);
   endtask

   task automatic exp_rd(input int m, input logic [31:0] d);
      rd_t e;
      e.m = m; e.data = d;
      rd_q.push_back(e);
   endtask

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: slave-side accepts and master-side read returns.
   always @(negedge clk) begin
      if (s_req[REQ_W-1] && s_ready) begin
         total++;
         if (acc_q.size() == 0) begin
            bad++;
            $display("FAIL accept unexpected actual=%0h required=none", s_req);
         end else begin
            acc_t e;
            logic [69:0] got, want;
            e    = acc_q.pop_front();
            got  = {m1_resp[0], m0_resp[0], s_req[REQ_W-2:0]};
            want = {e.m == 1, e.m == 0, e.addr, e.wdata, e.wstrb};
            if (got !== want) begin
               bad++;
               $display("FAIL accept m%0d actual=%0h required=%0h", e.m, got, want);
            end else begin
               $display("accept m%0d addr=%0h wdata=%0h wstrb=%0h", e.m, e.addr, e.wdata, e.wstrb);
            end
         end
      end
      for (int m = 0; m < 2; m++) begin
         logic [RESP_W-1:0] r;
         r = (m == 0) ? m0_resp : m1_resp;
         total++;
         if (r[1]) begin
            if (rd_q.size() == 0) begin
               bad++;
               $display("FAIL rvalid m%0d unexpected actual=%0h required=none", m, r[RESP_W-1:2]);
            end else begin
               rd_t e;
               e = rd_q.pop_front();
               if (e.m != m || r[RESP_W-1:2] !== e.data) begin
                  bad++;
                  $display("FAIL rdata actual=m%0d:%0h required=m%0d:%0h", m, r[RESP_W-1:2], e.m, e.data);
               end else begin
                  $display("read return m%0d rdata=%0h", m, e.data);
               end
            end
         end else if (r[RESP_W-1:2] !== '0) begin
            bad++;
            $display("FAIL idle rdata m%0d actual=%0h required=0", m, r[RESP_W-1:2]);
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int g;
      m0_req = '0; m1_req = '0;
      s_ready = 1'b1; s_rvalid = 1'b0; s_rdata = '0;

      // Reset state
      rst = 1'b1;
      repeat (3) tick();
      #1;
      check("reset s_req", s_req, 0);
      check("reset m0_resp", m0_resp, 0);
      check("reset m1_resp", m1_resp, 0);
      rst = 1'b0;
      tick();

      // 1: m0 read, data returns three cycles later
      drive(0, 1, 32'h100, 0, 0); exp_acc(0, 32'h100, 0, 0); tick();
      drive(0, 0, 0, 0, 0); tick(); tick();
      s_rvalid = 1; s_rdata = 32'hDEADBEEF; exp_rd(0, 32'hDEADBEEF);
      #1 check("t1 m1 rvalid", m1_resp[1], 0);
      tick();
      s_rvalid = 0; s_rdata = 0;

      // 2: m0 read and m1 write together, write goes first
      drive(0, 1, 32'h104, 0, 0); drive(1, 1, 32'h200, 32'h5A, 4'hF);
      exp_acc(1, 32'h200, 32'h5A, 4'hF);
      #1 check("t2 m0 stalled", m0_resp[0], 0);
      tick();
      drive(1, 0, 0, 0, 0); exp_acc(0, 32'h104, 0, 0); tick();
      drive(0, 0, 0, 0, 0);
      s_rvalid = 1; s_rdata = 32'h11112222; exp_rd(0, 32'h11112222); tick();
      s_rvalid = 0; s_rdata = 0;

      // 3: both masters read back to back, four rounds from a fresh reset
      rst = 1; tick(); rst = 0;
      drive(0, 1, 32'h300, 0, 0); drive(1, 1, 32'h400, 0, 0);
      for (int i = 0; i < 4; i++) begin
`ifdef IOB_BUS_MERGE2_RR_EN
         g = i % 2;
`else
         g = 1;
`endif
         exp_acc(g, (g == 1) ? 32'h400 : 32'h300, 0, 0); tick();
         s_rvalid = 1; s_rdata = 32'hA000_0000 + 32'(i); exp_rd(g, 32'hA000_0000 + 32'(i)); tick();
         s_rvalid = 0; s_rdata = 0;
      end
      drive(0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0); tick();

      // 4: m1 read outstanding blocks m0 until rvalid
      drive(1, 1, 32'h500, 0, 0); exp_acc(1, 32'h500, 0, 0); tick();
      drive(1, 0, 0, 0, 0); drive(0, 1, 32'h600, 0, 0);
      for (int i = 0; i < 3; i++) begin
         #1 check("t4 m0 ready", m0_resp[0], 0);
         check("t4 s avalid", s_req[REQ_W-1], 0);
         tick();
      end
      s_rvalid = 1; s_rdata = 32'hCAFEF00D; exp_rd(1, 32'hCAFEF00D);
      #1 check("t4 m0 ready at rvalid", m0_resp[0], 0);
      tick();
      s_rvalid = 0; s_rdata = 0; exp_acc(0, 32'h600, 0, 0); tick();
      drive(0, 0, 0, 0, 0);
      s_rvalid = 1; s_rdata = 32'h00600600; exp_rd(0, 32'h00600600); tick();
      s_rvalid = 0; s_rdata = 0;

      // 5: reset during RD_WAIT drops the read; late rvalid is ignored
      drive(0, 1, 32'h700, 0, 0); exp_acc(0, 32'h700, 0, 0); tick();
      drive(0, 0, 0, 0, 0); rst = 1;
      #1 check("t5 reset s_req", s_req, 0);
      tick();
      rst = 0; s_rvalid = 1; s_rdata = 32'hBAD0BAD0;
      drive(1, 1, 32'h800, 32'h77, 4'h3); exp_acc(1, 32'h800, 32'h77, 4'h3);
      #1 check("t5 m1 ready in idle", m1_resp[0], 1);
      check("t5 m0 rvalid", m0_resp[1], 0);
      tick();
      drive(1, 0, 0, 0, 0); s_rvalid = 0; s_rdata = 0; tick();

      // 6: cke low in RD_WAIT: data forwarded, state held
      drive(0, 1, 32'h900, 0, 0); exp_acc(0, 32'h900, 0, 0); tick();
      drive(0, 0, 0, 0, 0); cke = 0;
      s_rvalid = 1; s_rdata = 32'h600D600D;
      drive(1, 1, 32'hA00, 32'h1, 4'h1);
      for (int i = 0; i < 5; i++) begin
         exp_rd(0, 32'h600D600D);
         #1 check("t6 m1 ready frozen", m1_resp[0], 0);
         tick();
      end
      cke = 1; exp_rd(0, 32'h600D600D);
      #1 check("t6 m1 ready at release", m1_resp[0], 0);
      tick();
      s_rvalid = 0; s_rdata = 0; exp_acc(1, 32'hA00, 32'h1, 4'h1); tick();
      drive(1, 0, 0, 0, 0); tick(); tick();

      check("accept queue drained", 128'(acc_q.size()), 0);
      check("read queue drained", 128'(rd_q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
